// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage and IF/ID pipeline register for the
// 5-stage MIPS pipeline.
//
// The stage holds the PC and fetches from instruction memory through a
// req/ready handshake. It picks the next PC from sequential fetch or from a
// redirect (JR, J/JAL, taken branch) that the ID stage resolves.
//
// Optional feature macro: BRANCH_DELAY_SLOT_EN
//   defined     : the word fetched alongside a redirect (the delay slot) is
//                 kept in IF/ID as a valid instruction.
//   not defined : that word is flushed and a bubble is inserted.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   stall           hazard unit hold request for PC and IF/ID
//   branch          ID compare result (1 = branch condition true)
//   is_branch_id    ID instruction is a conditional branch
//   jump_id         ID instruction is J/JAL
//   jr_id           ID instruction is JR/JALR
//   imm_id          ID branch offset field (16 bits)
//   jidx_id         ID jump index field (26 bits)
//   data_a          forwarded rs value, used as the JR target
//   imem_req        fetch request to instruction memory
//   imem_addr       word-aligned fetch address
//   imem_ready      imem_rdata is valid for the current request
//   imem_rdata      fetched instruction word
//   instr_id        IF/ID instruction
//   pc4_id          IF/ID PC+4
//   valid_id        IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        is_branch_id,
  input  logic        jump_id,
  input  logic        jr_id,
  input  logic [15:0] imm_id,
  input  logic [25:0] jidx_id,
  input  logic [31:0] data_a,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_id,
  output logic [31:0] pc4_id,
  output logic        valid_id
);

  typedef enum logic {
    FETCH,
    DRAIN
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redir_pc;
  logic        req_q;

  logic        redirect;
  logic        fetch_ok;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] target_al;

  // req_q is cleared asynchronously, so an in-flight request (even mid-DRAIN)
  // disappears at the instant reset is asserted.
  assign imem_req  = req_q;
  // The PC is only updated once a word has been accepted, so the address
  // stays stable for the whole handshake, including while draining.
  assign imem_addr = pc;

  // A word is only accepted against a request that is actually up.
  assign fetch_ok  = imem_ready & req_q;
  assign pc_plus4  = pc + 32'd4;
  assign redirect  = ~stall & valid_id & (jr_id | jump_id | (is_branch_id & branch));

  always_comb begin
    target = pc4_id + {{14{imm_id[15]}}, imm_id, 2'b00};
    if (jr_id) begin
      target = data_a;
    end else if (jump_id) begin
      target = {pc4_id[31:28], jidx_id, 2'b00};
    end
  end

  // Only bits [31:2] of a target are meaningful; the PC stays word aligned.
  assign target_al = {target[31:2], 2'b00};

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would let pc/IF-ID updates
  // race each other within the same clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every register here is a plain flop (no memory array), so all
      // of them, redir_pc included, get a defined reset value.
      state    <= FETCH;
      pc       <= RESET_PC;
      redir_pc <= RESET_PC;
      req_q    <= 1'b0;
      instr_id <= NOP_INSTR;
      pc4_id   <= 32'h0000_0000;
      valid_id <= 1'b0;
    end else begin
      req_q <= 1'b1;
      case (state)
        FETCH: begin
          // A stall freezes PC and IF/ID; a word returned now is not
          // consumed and is sampled again next cycle at the same address.
          if (!stall) begin
            if (redirect) begin
              if (fetch_ok) begin
                pc <= target_al;
`ifdef BRANCH_DELAY_SLOT_EN
                instr_id <= imem_rdata;
                pc4_id   <= pc_plus4;
                valid_id <= 1'b1;
`else
                instr_id <= NOP_INSTR;
                valid_id <= 1'b0;
`endif
              end else begin
                // The outstanding request must complete before the PC can
                // move, so park the target and wait for it.
                redir_pc <= target_al;
                instr_id <= NOP_INSTR;
                valid_id <= 1'b0;
                state    <= DRAIN;
              end
            end else if (fetch_ok) begin
              instr_id <= imem_rdata;
              pc4_id   <= pc_plus4;
              valid_id <= 1'b1;
              pc       <= pc_plus4;
            end else begin
              instr_id <= NOP_INSTR;
              valid_id <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // valid_id is already 0 here, so no new redirect can arrive.
          if (fetch_ok) begin
            pc    <= redir_pc;
            state <= FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
            instr_id <= imem_rdata;
            pc4_id   <= pc_plus4;
            valid_id <= 1'b1;
`else
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
`endif
          end else begin
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed self-checking bench for if_stage.
//
// Instruction memory is modelled as word = {16'hA5A5, addr[15:0]}, so every
// expected instruction is a hand-written constant. Inputs change 1 ns after
// a rising edge and outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic        is_branch_id;
  logic        jump_id;
  logic        jr_id;
  logic [15:0] imm_id;
  logic [25:0] jidx_id;
  logic [31:0] data_a;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_id;
  logic [31:0] pc4_id;
  logic        valid_id;

  int n_vec = 0;
  int n_err = 0;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch       (branch),
    .is_branch_id (is_branch_id),
    .jump_id      (jump_id),
    .jr_id        (jr_id),
    .imm_id       (imm_id),
    .jidx_id      (jidx_id),
    .data_a       (data_a),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_id     (instr_id),
    .pc4_id       (pc4_id),
    .valid_id     (valid_id)
  );

  assign imem_rdata = {16'hA5A5, imem_addr[15:0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a cycle that delivers a valid instruction.
  task automatic check_word(input string tag, input logic [31:0] exp_instr,
                            input logic [31:0] exp_pc4, input logic [31:0] exp_addr);
    check({tag, ".valid"}, {31'd0, valid_id}, 32'd1);
    check({tag, ".instr"}, instr_id, exp_instr);
    check({tag, ".pc4"},   pc4_id, exp_pc4);
    check({tag, ".addr"},  imem_addr, exp_addr);
  endtask

  // Checks a bubble cycle.
  task automatic check_bubble(input string tag, input logic [31:0] exp_addr);
    check({tag, ".valid"}, {31'd0, valid_id}, 32'd0);
    check({tag, ".instr"}, instr_id, 32'h0000_0000);
    check({tag, ".addr"},  imem_addr, exp_addr);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch = 1'b0; is_branch_id = 1'b0;
    jump_id = 1'b0; jr_id = 1'b0; imm_id = 16'h0; jidx_id = 26'h0;
    data_a = 32'h0; imem_ready = 1'b1;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst.req",   {31'd0, imem_req}, 32'd0);
    check("rst.addr",  imem_addr, 32'h0000_3000);
    check("rst.valid", {31'd0, valid_id}, 32'd0);
    check("rst.instr", instr_id, 32'h0000_0000);
    check("rst.pc4",   pc4_id, 32'h0000_0000);
    reset = 1'b0;
    #1;
    check("rel.req0", {31'd0, imem_req}, 32'd0);

    // First edge after release raises req; nothing is consumed yet.
    step();
    check("rel.req1", {31'd0, imem_req}, 32'd1);
    check_bubble("rel", 32'h0000_3000);

    // Back-to-back fetches.
    step(); check_word("w0", 32'hA5A5_3000, 32'h0000_3004, 32'h0000_3004);
    step(); check_word("w1", 32'hA5A5_3004, 32'h0000_3008, 32'h0000_3008);

    // Stall two cycles at pc=3008 with ready high: everything frozen.
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_word("stall", 32'hA5A5_3004, 32'h0000_3008, 32'h0000_3008);
      check("stall.req", {31'd0, imem_req}, 32'd1);
    end
    stall = 1'b0;
    step(); check_word("w2", 32'hA5A5_3008, 32'h0000_300C, 32'h0000_300C);

    // Taken beq at pc4_id=300C, offset -3 words -> target 3000.
    is_branch_id = 1'b1; branch = 1'b1; imm_id = 16'hFFFD;
    step();
    is_branch_id = 1'b0; branch = 1'b0; imm_id = 16'h0;
`ifdef BRANCH_DELAY_SLOT_EN
    check_word("beq", 32'hA5A5_300C, 32'h0000_3010, 32'h0000_3000);
`else
    check_bubble("beq", 32'h0000_3000);
`endif
    step(); check_word("beq.tgt", 32'hA5A5_3000, 32'h0000_3004, 32'h0000_3004);

    // JR to 4003 (low bits dropped -> 4000) while memory is not ready.
    jr_id = 1'b1; data_a = 32'h0000_4003; imem_ready = 1'b0;
    step();
    jr_id = 1'b0;
    check_bubble("jr.d0", 32'h0000_3004);
    for (int i = 0; i < 2; i++) begin
      step();
      check_bubble("jr.drain", 32'h0000_3004);
    end
    imem_ready = 1'b1;
    step();
`ifdef BRANCH_DELAY_SLOT_EN
    check_word("jr.done", 32'hA5A5_3004, 32'h0000_3008, 32'h0000_4000);
`else
    check_bubble("jr.done", 32'h0000_4000);
`endif
    step(); check_word("jr.tgt", 32'hA5A5_4000, 32'h0000_4004, 32'h0000_4004);

    // Two not-ready cycles without stall: two bubbles, pc holds.
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_bubble("nrdy", 32'h0000_4004);
    end
    imem_ready = 1'b1;
    step(); check_word("nrdy.w", 32'hA5A5_4004, 32'h0000_4008, 32'h0000_4008);

    // J with index 0xC40 -> {pc4_id[31:28], 0xC40, 00} = 3100.
    jump_id = 1'b1; jidx_id = 26'h000_0C40;
    step();
    jump_id = 1'b0; jidx_id = 26'h0;
`ifdef BRANCH_DELAY_SLOT_EN
    check_word("j", 32'hA5A5_4008, 32'h0000_400C, 32'h0000_3100);
`else
    check_bubble("j", 32'h0000_3100);
`endif
    step(); check_word("j.tgt", 32'hA5A5_3100, 32'h0000_3104, 32'h0000_3104);

    // Branch not taken: sequential fetch continues.
    is_branch_id = 1'b1; branch = 1'b0; imm_id = 16'h0010;
    step();
    is_branch_id = 1'b0; imm_id = 16'h0;
    check_word("bnt", 32'hA5A5_3104, 32'h0000_3108, 32'h0000_3108);

    // Enter DRAIN, then assert reset asynchronously between edges.
    jr_id = 1'b1; data_a = 32'h0000_5000; imem_ready = 1'b0;
    step();
    jr_id = 1'b0;
    check_bubble("ar.drain", 32'h0000_3108);
    reset = 1'b1;
    #1;
    check("ar.req",  {31'd0, imem_req}, 32'd0);
    check("ar.addr", imem_addr, 32'h0000_3000);
    #2;
    reset = 1'b0;
    imem_ready = 1'b1;
    step();
    check("ar.req1", {31'd0, imem_req}, 32'd1);
    check_bubble("ar.rel", 32'h0000_3000);
    step(); check_word("ar.w0", 32'hA5A5_3000, 32'h0000_3004, 32'h0000_3004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
